channel_selector: RTL and testbench

//  Upstream driver for the 4:1 test-signal mux. It turns two raw active-low push-buttons
//  (NEXT, PREV) into the registered 2-bit channel select the mux consumes.

---
 rtl/channel_selector_pkg.sv | 41 ++++
 rtl/channel_selector_button_debounce.sv | 73 +++++++
 rtl/channel_selector.sv | 154 +++++++++++++++
 tb/tb_channel_selector.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_selector_pkg.sv
// Shared definitions for the channel selector: channel codes, select width,
// repeat-FSM state encoding and small helpers for cycle-count arithmetic.
package channel_selector_pkg;

    localparam int SEL_W  = 2;
    localparam int CH_NUM = 4;

    localparam logic [SEL_W-1:0] CH_ZERO = 2'd0;
    localparam logic [SEL_W-1:0] CH_1HZ  = 2'd1;
    localparam logic [SEL_W-1:0] CH_10HZ = 2'd2;
    localparam logic [SEL_W-1:0] CH_ONE  = 2'd3;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Milliseconds to clock cycles, done in 32-bit integer arithmetic.
    function automatic int ms_to_cyc(input int clk_freq, input int ms);
        return ms * (clk_freq / 1000);
    endfunction

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // LED pattern for a channel: bit number 'sel' is lit.
    function automatic logic [CH_NUM-1:0] onehot_of(input logic [SEL_W-1:0] sel);
        logic [CH_NUM-1:0] r;
        r      = '0;
        r[sel] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/channel_selector_button_debounce.sv
// Two-flop synchroniser plus stability debouncer for one active-low key.
// 'pressed' is the debounced level; 'press_evt' pulses for one cycle on the
// edge after the debounced level goes released->pressed.
module button_debounce
    import channel_selector_pkg::*;
#(
    parameter int CLK_FREQ    = 50000000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic pressed,
    output logic press_evt
);

    localparam int DB_CYC = ms_to_cyc(CLK_FREQ, DEBOUNCE_MS);
    localparam int CNT_W  = cnt_width(DB_CYC);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1_q, sync2_q;
    logic             db_q, db_d;
    logic             db_prev_q;
    logic             evt_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sample_pressed;

    // Bring the raw key into the clock domain; idle level is released (1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing samples; flip once the count hits its end.
    always_comb begin
        sample_pressed = ~sync2_q;
        db_d           = db_q;
        cnt_d          = '0;
        if (sample_pressed != db_q) begin
            if (cnt_q == DB_LAST) begin
                db_d  = ~db_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // Debounced level, its one-cycle-old copy and the registered press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            evt_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            db_q      <= db_d;
            db_prev_q <= db_q;
            evt_q     <= db_q & ~db_prev_q;
            cnt_q     <= cnt_d;
        end
    end

    assign pressed   = db_q;
    assign press_evt = evt_q;

endmodule

// File: rtl/channel_selector.sv
// Turns debounced NEXT/PREV keys (with auto-repeat) into a registered 2-bit
// channel select for the 4:1 test-signal mux, plus one-hot LEDs and a strobe.
//
// Repeat FSM (one per key):
//   state      | meaning
//   RPT_IDLE   | key released or press not yet seen
//   RPT_DELAY  | key held after press, waiting out the initial repeat delay
//   RPT_REPEAT | key still held, stepping once per repeat period
//
// Index 0 of every per-key vector is NEXT, index 1 is PREV.
module channel_selector
    import channel_selector_pkg::*;
#(
    parameter int CLK_FREQ        = 50000000,
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_next_n,
    input  logic              btn_prev_n,
    output logic [SEL_W-1:0]  sel,
    output logic [CH_NUM-1:0] sel_onehot,
    output logic              sel_changed
);

    localparam int RD_CYC = ms_to_cyc(CLK_FREQ, REPEAT_DELAY_MS);
    localparam int RR_CYC = ms_to_cyc(CLK_FREQ, REPEAT_RATE_MS);
    localparam int RC_W   = cnt_width(max_int(RD_CYC, RR_CYC));
    localparam logic [RC_W-1:0] RD_LOAD = RC_W'(RD_CYC - 1);
    localparam logic [RC_W-1:0] RR_LOAD = RC_W'(RR_CYC - 1);
    localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);

    logic [1:0]        pressed;
    logic [1:0]        press_evt;
    logic [1:0]        rpt_evt;
    rpt_state_e        state_q [2];
    logic [RC_W-1:0]   rcnt_q  [2];

    logic              step_up, step_dn;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CH_NUM-1:0] onehot_q;
    logic              changed_q, changed_d;

    button_debounce #(
        .CLK_FREQ    (CLK_FREQ),
        .DEBOUNCE_MS (DEBOUNCE_MS)
    ) u_db_next (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_n     (btn_next_n),
        .pressed   (pressed[0]),
        .press_evt (press_evt[0])
    );

    button_debounce #(
        .CLK_FREQ    (CLK_FREQ),
        .DEBOUNCE_MS (DEBOUNCE_MS)
    ) u_db_prev (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_n     (btn_prev_n),
        .pressed   (pressed[1]),
        .press_evt (press_evt[1])
    );

    // Repeat timers: down-counters reloaded on entry, terminal count at zero.
    // A release drops straight back to idle and discards the running count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= RPT_IDLE;
                rcnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!pressed[i]) begin
                    state_q[i] <= RPT_IDLE;
                    rcnt_q[i]  <= '0;
                end else begin
                    case (state_q[i])
                        RPT_IDLE: begin
                            if (press_evt[i]) begin
                                state_q[i] <= RPT_DELAY;
                                rcnt_q[i]  <= RD_LOAD;
                            end
                        end
                        RPT_DELAY: begin
                            if (rcnt_q[i] == '0) begin
                                state_q[i] <= RPT_REPEAT;
                                rcnt_q[i]  <= RR_LOAD;
                            end else begin
                                rcnt_q[i]  <= rcnt_q[i] - RC_ONE;
                            end
                        end
                        RPT_REPEAT: begin
                            if (rcnt_q[i] == '0) begin
                                rcnt_q[i] <= RR_LOAD;
                            end else begin
                                rcnt_q[i] <= rcnt_q[i] - RC_ONE;
                            end
                        end
                        default: begin
                            state_q[i] <= RPT_IDLE;
                            rcnt_q[i]  <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // Repeat pulse at terminal count; gated by the level so a key released
    // on the same cycle as the terminal count never produces a late step.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rpt_evt[i] = pressed[i] && (state_q[i] != RPT_IDLE) && (rcnt_q[i] == '0);
        end
    end

    // Step decision with wrap-around; simultaneous up and down cancel.
    always_comb begin
        step_up   = press_evt[0] | rpt_evt[0];
        step_dn   = press_evt[1] | rpt_evt[1];
        sel_d     = sel_q;
        changed_d = 1'b0;
        if (step_up && !step_dn) begin
            sel_d     = sel_q + SEL_W'(1);
            changed_d = 1'b1;
        end else if (step_dn && !step_up) begin
            sel_d     = sel_q - SEL_W'(1);
            changed_d = 1'b1;
        end
    end

    // Registered outputs; LEDs follow sel on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q     <= CH_ZERO;
            onehot_q  <= onehot_of(CH_ZERO);
            changed_q <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            onehot_q  <= onehot_of(sel_d);
            changed_q <= changed_d;
        end
    end

    assign sel         = sel_q;
    assign sel_onehot  = onehot_q;
    assign sel_changed = changed_q;

endmodule

// File: tb/tb_channel_selector.sv
// Bench for channel_selector at 1 kHz: DB=4, RD=20, RR=10 cycles.
// A time-based behavioural model predicts sel/onehot/strobe every cycle;
// directed sections pin key edges with literal expectations, then random keys.
module tb_channel_selector;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_next_n = 1'b1;
    logic       btn_prev_n = 1'b1;
    logic [1:0] sel;
    logic [3:0] sel_onehot;
    logic       sel_changed;

    int tot = 0;
    int bad = 0;

    channel_selector #(
        .CLK_FREQ        (1000),
        .DEBOUNCE_MS     (4),
        .REPEAT_DELAY_MS (20),
        .REPEAT_RATE_MS  (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_next_n  (btn_next_n),
        .btn_prev_n  (btn_prev_n),
        .sel         (sel),
        .sel_onehot  (sel_onehot),
        .sel_changed (sel_changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tot++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each key: the debouncer sees the raw level two edges late; the debounced
    // level flips after DB consecutive disagreeing samples. A step event is
    // visible after edge pe (press) and after pe+RD+k*RR, while still pressed.
    bit         m_d1 [2];
    bit         m_d2 [2];
    bit         m_deb[2];
    bit         m_ev [2];
    bit         m_raw[2];
    int         m_run[2];
    int         m_pe [2];
    int         m_e = 0;
    logic [1:0] m_sel = 2'd0;
    bit         m_chg = 1'b0;
    bit         m_up, m_dn;

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_sel = 2'd0;
            m_chg = 1'b0;
            m_e   = 0;
            for (int b = 0; b < 2; b++) begin
                m_d1[b]  = 1'b0;
                m_d2[b]  = 1'b0;
                m_deb[b] = 1'b0;
                m_ev[b]  = 1'b0;
                m_run[b] = 0;
                m_pe[b]  = -1;
            end
        end else begin
            m_e++;
            m_up  = m_ev[0];
            m_dn  = m_ev[1];
            m_chg = m_up ^ m_dn;
            if (m_up && !m_dn) m_sel = m_sel + 2'd1;
            else if (m_dn && !m_up) m_sel = m_sel - 2'd1;
            m_raw[0] = ~btn_next_n;
            m_raw[1] = ~btn_prev_n;
            for (int b = 0; b < 2; b++) begin
                if (m_d2[b] != m_deb[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DB) begin
                        m_deb[b] = ~m_deb[b];
                        m_run[b] = 0;
                        if (m_deb[b]) m_pe[b] = m_e + 1;
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_d2[b] = m_d1[b];
                m_d1[b] = m_raw[b];
                m_ev[b] = m_deb[b] && ((m_e == m_pe[b]) ||
                          ((m_e - m_pe[b] >= RD) && ((m_e - m_pe[b] - RD) % RR == 0)));
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always begin
        @(posedge clk);
        #1;
        chk("cyc_sel", int'(sel), int'(m_sel));
        chk("cyc_onehot", int'(sel_onehot), int'(4'b0001 << m_sel));
        chk("cyc_changed", int'(sel_changed), int'(m_chg));
    end

    // Drive both keys (0 = pressed) for n cycles; starts and ends on a negedge.
    task automatic hold(input logic nx, input logic pv, input int n);
        btn_next_n = nx;
        btn_prev_n = pv;
        repeat (n) @(negedge clk);
    endtask

    int n_str;
    int first_e;
    int last_e;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: idle after reset
        n_str = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (sel_changed) n_str++;
        end
        chk("idle_strobes", n_str, 0);
        chk("idle_sel", int'(sel), 0);
        chk("idle_onehot", int'(sel_onehot), 1);
        @(negedge clk);

        // 2: clean press, latency DB+4 = 8 edges after the fall
        hold(1'b0, 1'b1, 6);
        btn_next_n = 1'b1;
        @(posedge clk); #1;
        chk("lat_edge7_sel", int'(sel), 0);
        @(posedge clk); #1;
        chk("lat_edge8_sel", int'(sel), 1);
        chk("lat_edge8_onehot", int'(sel_onehot), 2);
        chk("lat_edge8_strobe", int'(sel_changed), 1);
        chk("model_pin_sel", int'(m_sel), 1);
        @(posedge clk); #1;
        chk("lat_edge9_strobe", int'(sel_changed), 0);
        @(negedge clk);
        hold(1'b1, 1'b1, 15);

        // 3: bounce then stay low -> one step; 3-cycle glitches -> none
        hold(1'b0, 1'b1, 1);
        hold(1'b1, 1'b1, 1);
        hold(1'b0, 1'b1, 1);
        hold(1'b1, 1'b1, 1);
        hold(1'b0, 1'b1, 10);
        hold(1'b1, 1'b1, 15);
        chk("bounce_sel", int'(sel), 2);
        hold(1'b0, 1'b1, 3);
        hold(1'b1, 1'b1, 10);
        hold(1'b0, 1'b1, 3);
        hold(1'b1, 1'b1, 15);
        chk("glitch_sel", int'(sel), 2);

        // 4: wrap both ways
        hold(1'b0, 1'b1, 6);
        hold(1'b1, 1'b1, 15);
        chk("step_to3", int'(sel), 3);
        hold(1'b0, 1'b1, 6);
        hold(1'b1, 1'b1, 15);
        chk("wrap_up_sel", int'(sel), 0);
        chk("wrap_up_onehot", int'(sel_onehot), 1);
        hold(1'b1, 1'b0, 6);
        hold(1'b1, 1'b1, 15);
        chk("wrap_dn_sel", int'(sel), 3);
        chk("wrap_dn_onehot", int'(sel_onehot), 8);

        // 5: hold NEXT 55 cycles past acceptance -> steps at edges 8,28,38,48,58
        n_str = 0; first_e = -1; last_e = -1;
        for (int i = 0; i < 90; i++) begin
            btn_next_n = (i < 61) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            if (sel_changed) begin
                n_str++;
                if (first_e < 0) first_e = i + 1;
                last_e = i + 1;
            end
            @(negedge clk);
        end
        chk("repeat_count", n_str, 5);
        chk("repeat_first_edge", first_e, 8);
        chk("repeat_last_edge", last_e, 58);
        chk("repeat_sel", int'(sel), 0);

        // 6a: both keys together, including coinciding repeats -> no change
        n_str = 0;
        for (int i = 0; i < 60; i++) begin
            btn_next_n = (i < 40) ? 1'b0 : 1'b1;
            btn_prev_n = (i < 40) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            if (sel_changed) n_str++;
            @(negedge clk);
        end
        chk("both_strobes", n_str, 0);
        chk("both_sel", int'(sel), 0);

        // 6b: reset while NEXT is auto-repeating
        hold(1'b0, 1'b1, 40);
        chk("pre_reset_sel", int'(sel), 3);
        rst_n = 1'b0;
        #1;
        chk("async_rst_sel", int'(sel), 0);
        chk("async_rst_onehot", int'(sel_onehot), 1);
        chk("async_rst_strobe", int'(sel_changed), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("post_rst_edge7_sel", int'(sel), 0);
        @(posedge clk); #1;
        chk("post_rst_edge8_sel", int'(sel), 1);
        @(negedge clk);
        hold(1'b1, 1'b1, 20);

        // random keys with occasional resets, checked by the model every cycle
        for (int s = 0; s < 200; s++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end else begin
                hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(1, 45)));
            end
        end
        hold(1'b1, 1'b1, 20);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
